// File: rtl/sort_share_arb.sv
// sort_share_arb
// Shares a single external 6-input sorting network between NUM_REQ
// requesters. Requests are granted round-robin, the winner's vector is
// driven onto srt_in, ownership is tracked through the sorter latency by a
// tag pipeline, and sorted results are returned in issue order through a
// small response FIFO.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   req_valid/req_data   per-requester request handshake; vector i at
//                        req_data[i*6*DATA_W +: 6*DATA_W]
//   req_ready            one-hot grant (or zero)
//   srt_valid/srt_in     issue strobe and vector presented to the sorter
//   srt_out              sorter result, ascending, SORT_LAT cycles later
//   rsp_valid            one-hot owner of the FIFO head
//   rsp_data/rsp_median  FIFO head vector and its element 2
//   rsp_ready            per-requester response accept
//   busy                 results in flight or buffered
module sort_share_arb #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_W     = 32,
    parameter int SORT_LAT   = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*6*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        srt_valid,
    output logic [6*DATA_W-1:0]         srt_in,
    input  logic [6*DATA_W-1:0]         srt_out,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [6*DATA_W-1:0]         rsp_data,
    output logic [DATA_W-1:0]           rsp_median,
    input  logic [NUM_REQ-1:0]          rsp_ready,
    output logic                        busy
);
    localparam int VEC_W = 6 * DATA_W;
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [ID_W-1:0]  rr_ptr_reg;
    logic [ID_W-1:0]  rr_ptr_next;
    logic [ID_W-1:0]  cand_id [NUM_REQ];
    logic [ID_W-1:0]  grant_id;
    logic             grant_found;
    logic [CNT_W-1:0] inflight;
    logic [CNT_W:0]   used;
    logic             can_issue;
    logic             accept;
    logic             wr_en;
    logic [ID_W-1:0]  wr_id;

    logic [VEC_W-1:0] data_mem [FIFO_DEPTH];
    logic [ID_W-1:0]  id_mem   [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] fifo_count_reg;
    logic [CNT_W-1:0] fifo_count_next;
    logic             fifo_empty;
    logic [ID_W-1:0]  head_id;
    logic             pop;

    // Candidate order for this cycle: rr_ptr, rr_ptr+1, ... wrapped.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            logic [ID_W:0] raw;
            assign raw = {1'b0, rr_ptr_reg} + (ID_W+1)'(gi);
            assign cand_id[gi] = (raw >= (ID_W+1)'(NUM_REQ)) ?
                                 ID_W'(raw - (ID_W+1)'(NUM_REQ)) : raw[ID_W-1:0];
        end
    endgenerate

    // Walk candidates from last to first so the earliest match wins.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[cand_id[k]]) begin
                grant_found = 1'b1;
                grant_id    = cand_id[k];
            end
        end
    end

    // Credits use registered counts only, so a pop frees a slot next cycle.
    assign used      = {1'b0, inflight} + {1'b0, fifo_count_reg};
    assign can_issue = used < (CNT_W+1)'(FIFO_DEPTH);
    // rst_n gating keeps the handshake quiet while reset is held.
    assign accept    = rst_n & can_issue & grant_found;

    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = accept & (grant_id == ID_W'(gi));
        end
    endgenerate

    assign srt_valid = accept;
    assign srt_in    = accept ? req_data[grant_id*VEC_W +: VEC_W] : '0;

    assign rr_ptr_next = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_reg <= '0;
        end else if (accept) begin
            rr_ptr_reg <= rr_ptr_next;
        end
    end

    // Ownership tags travel alongside the sorter pipeline.
    generate
        if (SORT_LAT == 0) begin : g_nolat
            assign wr_en    = accept;
            assign wr_id    = grant_id;
            assign inflight = '0;
        end else begin : g_lat
            logic [SORT_LAT-1:0] tag_valid_reg;
            logic [ID_W-1:0]     tag_id_reg [SORT_LAT];
            logic [CNT_W-1:0]    inflight_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    tag_valid_reg <= '0;
                    for (int s = 0; s < SORT_LAT; s++) begin
                        tag_id_reg[s] <= '0;
                    end
                    inflight_reg <= '0;
                end else begin
                    tag_valid_reg[0] <= accept;
                    tag_id_reg[0]    <= grant_id;
                    for (int s = 1; s < SORT_LAT; s++) begin
                        tag_valid_reg[s] <= tag_valid_reg[s-1];
                        tag_id_reg[s]    <= tag_id_reg[s-1];
                    end
                    inflight_reg <= inflight_reg + CNT_W'(accept)
                                    - CNT_W'(tag_valid_reg[SORT_LAT-1]);
                end
            end

            assign wr_en    = tag_valid_reg[SORT_LAT-1];
            assign wr_id    = tag_id_reg[SORT_LAT-1];
            assign inflight = inflight_reg;
        end
    endgenerate

    // Response FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[wr_ptr_reg] <= srt_out;
            id_mem[wr_ptr_reg]   <= wr_id;
        end
    end

    assign fifo_empty = (fifo_count_reg == '0);
    assign head_id    = id_mem[rd_ptr_reg];

    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
            assign rsp_valid[gi] = !fifo_empty && (head_id == ID_W'(gi));
        end
    endgenerate

    // Only the head owner's rsp_ready can pop.
    assign pop             = |(rsp_valid & rsp_ready);
    assign fifo_count_next = fifo_count_reg + CNT_W'(wr_en) - CNT_W'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            fifo_count_reg <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= (wr_ptr_reg == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= (rd_ptr_reg == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
            end
            fifo_count_reg <= fifo_count_next;
        end
    end

    assign rsp_data   = fifo_empty ? '0 : data_mem[rd_ptr_reg];
    assign rsp_median = rsp_data[2*DATA_W +: DATA_W];
    assign busy       = (inflight != '0) || !fifo_empty;

endmodule
